// File: rtl/dram.sv
// rtl/dram.sv - single-port data RAM with byte-aligned loads, lane-selected stores and sticky misalign capture
module dram #(
    parameter int AW = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Data_addr,
    input  logic [31:0] Data_out,
    input  logic        we,
    input  logic [1:0]  wa,
    output logic [31:0] Data_in,
    output logic        misalign_err,
    output logic [31:0] err_addr
);

    localparam int DEPTH = 1 << AW;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic [31:0]   rd_word;
    logic [3:0]    lane_en;
    logic [31:0]   lane_data;
    logic          aligned;
    logic [31:0]   wr_word_d;
    logic          err_q, err_d;
    logic [31:0]   err_addr_q, err_addr_d;

    assign idx     = Data_addr[AW+1:2];
    assign off     = Data_addr[1:0];
    assign rd_word = mem_q[idx];

    // Load path: shift the addressed byte down to bit 0, zero-filling the top
    assign Data_in = rd_word >> {off, 3'b000};

    // Store decode: replicate store data across lanes and pick the enabled lanes
    always_comb begin
        aligned   = 1'b1;
        lane_en   = 4'b1111;
        lane_data = Data_out;
        case (wa)
            2'd0: begin
                lane_en   = 4'b0001 << off;
                lane_data = {4{Data_out[7:0]}};
            end
            2'd1: begin
                aligned   = ~off[0];
                lane_en   = off[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{Data_out[15:0]}};
            end
            default: begin
                aligned = (off == 2'd0);
            end
        endcase
    end

    // Merge enabled lanes into the current word contents
    always_comb begin
        wr_word_d = rd_word;
        for (int b = 0; b < 4; b++) begin
            if (lane_en[b]) begin
                wr_word_d[8*b +: 8] = lane_data[8*b +: 8];
            end
        end
    end

    // Storage array: cleared by reset, written only by aligned stores
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (we && aligned) begin
            mem_q[idx] <= wr_word_d;
        end
    end

    // First misaligned store latches the flag and its address; later ones are ignored
    always_comb begin
        err_d      = err_q;
        err_addr_d = err_addr_q;
        if (we && !aligned && !err_q) begin
            err_d      = 1'b1;
            err_addr_d = Data_addr;
        end
    end

    // Sticky error registers, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q      <= 1'b0;
            err_addr_q <= 32'd0;
        end else begin
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign misalign_err = err_q;
    assign err_addr     = err_addr_q;

endmodule

// File: tb/tb_dram.sv
// tb/tb_dram.sv - directed table-driven bench for dram
module tb_dram;

    logic        clk;
    logic        rst;
    logic [31:0] Data_addr;
    logic [31:0] Data_out;
    logic        we;
    logic [1:0]  wa;
    logic [31:0] Data_in;
    logic        misalign_err;
    logic [31:0] err_addr;

    int n_checks;
    int n_errors;

    dram #(.AW(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .Data_addr    (Data_addr),
        .Data_out     (Data_out),
        .we           (we),
        .wa           (wa),
        .Data_in      (Data_in),
        .misalign_err (misalign_err),
        .err_addr     (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  wa;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [31:0] exp_eaddr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input string n, input logic w, input logic [1:0] s, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] ra, input logic [31:0] er,
                       input logic ee, input logic [31:0] ea);
        vec_t v;
        v.name = n; v.we = w; v.wa = s; v.addr = a; v.wdata = d;
        v.raddr = ra; v.exp_rd = er; v.exp_err = ee; v.exp_eaddr = ea;
        vecs.push_back(v);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        we        = 1'b0;
        wa        = 2'd0;
        Data_addr = 32'h0;
        Data_out  = 32'h0;

        //   name        we wa  addr        wdata         raddr       exp_rd        err ea
        add("sw_10",     1, 2, 32'h10,  32'hDEADBEEF, 32'h10,  32'hDEADBEEF, 0, 32'h0);
        add("rd_11",     0, 2, 32'h10,  32'h0,        32'h11,  32'h00DEADBE, 0, 32'h0);
        add("rd_13",     0, 2, 32'h10,  32'h0,        32'h13,  32'h000000DE, 0, 32'h0);
        add("rd_alias",  0, 2, 32'h10,  32'h0,        32'h410, 32'hDEADBEEF, 0, 32'h0);
        add("sw_20",     1, 2, 32'h20,  32'h0,        32'h20,  32'h00000000, 0, 32'h0);
        add("sb_21",     1, 0, 32'h21,  32'hFFFFFFAA, 32'h20,  32'h0000AA00, 0, 32'h0);
        add("sh_22",     1, 1, 32'h22,  32'hABCD1234, 32'h20,  32'h1234AA00, 0, 32'h0);
        add("sw_30",     1, 2, 32'h30,  32'h11111111, 32'h30,  32'h11111111, 0, 32'h0);
        add("sw_34",     1, 2, 32'h34,  32'h77777777, 32'h34,  32'h77777777, 0, 32'h0);
        add("sh_31_bad", 1, 1, 32'h31,  32'h0000FFFF, 32'h30,  32'h11111111, 1, 32'h31);
        add("sw_36_bad", 1, 2, 32'h36,  32'h0,        32'h34,  32'h77777777, 1, 32'h31);
        add("w3_33_bad", 1, 3, 32'h33,  32'h0,        32'h30,  32'h11111111, 1, 32'h31);
        add("w3_50",     1, 3, 32'h50,  32'hCAFEF00D, 32'h50,  32'hCAFEF00D, 1, 32'h31);
        add("sb_53",     1, 0, 32'h53,  32'h1234565A, 32'h50,  32'h5AFEF00D, 1, 32'h31);
        add("sh_52",     1, 1, 32'h52,  32'h88889999, 32'h52,  32'h00009999, 1, 32'h31);
        add("we0_50",    0, 0, 32'h50,  32'h000000FF, 32'h50,  32'h9999F00D, 1, 32'h31);
        add("rd_53_hw",  0, 1, 32'h53,  32'h0,        32'h53,  32'h00000099, 1, 32'h31);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold_rd0", Data_in, 32'h0);
        rst = 1'b0;
        Data_addr = 32'h0;   #1; check("rst_rd_000", Data_in, 32'h0);
        Data_addr = 32'h3FC; #1; check("rst_rd_3fc", Data_in, 32'h0);
        Data_addr = 32'h400; #1; check("rst_rd_400", Data_in, 32'h0);
        check("rst_err",   {31'b0, misalign_err}, 32'h0);
        check("rst_eaddr", err_addr, 32'h0);

        // Table-driven vectors: one edge with the store, then read back
        foreach (vecs[i]) begin
            @(negedge clk);
            we = vecs[i].we; wa = vecs[i].wa;
            Data_addr = vecs[i].addr; Data_out = vecs[i].wdata;
            @(posedge clk);
            #1;
            we = 1'b0;
            Data_addr = vecs[i].raddr;
            #1;
            check({vecs[i].name, "_rd"},  Data_in, vecs[i].exp_rd);
            check({vecs[i].name, "_err"}, {31'b0, misalign_err}, {31'b0, vecs[i].exp_err});
            check({vecs[i].name, "_ea"},  err_addr, vecs[i].exp_eaddr);
        end

        // Read-during-write: old contents until the edge
        @(negedge clk);
        we = 1'b1; wa = 2'd2; Data_addr = 32'h40; Data_out = 32'h5;
        @(negedge clk);
        Data_out = 32'h9;
        #1;
        check("rdw_before", Data_in, 32'h5);
        @(posedge clk);
        #1;
        check("rdw_after", Data_in, 32'h9);
        we = 1'b0;

        // Asynchronous reset between edges, with a store held across the reset edge
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_rd", Data_in, 32'h0);
        check("arst_err", {31'b0, misalign_err}, 32'h0);
        check("arst_ea", err_addr, 32'h0);
        we = 1'b1; wa = 2'd2; Data_addr = 32'h60; Data_out = 32'h123;
        @(posedge clk);
        #1;
        we = 1'b0;
        rst = 1'b0;
        #1;
        check("arst_store_dropped", Data_in, 32'h0);
        Data_addr = 32'h40; #1;
        check("arst_mem_cleared", Data_in, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
